goertzel_tone_detector: RTL and testbench

- Single-bin Goertzel tone detector; the digital receive end of the AC stimulus/response path.
- Consumes a sampled filter output (e.g. Vout of the bandpass under test) one sample per handshake.
- Accumulates a block of N samples, then returns the squared magnitude at one programmed frequency.
- Used by regression benches to check pass-band gain and stop-band rejection against the analog AC result.

---
 rtl/goertzel_tone_detector.sv | 157 +++++++++++++++
 tb/tb_goertzel_tone_detector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_tone_detector.sv
`default_nettype none
// ============================================================================
// goertzel_tone_detector : single-bin Goertzel power detector over N samples
// Optional: GOERTZEL_RAW_STATE_EN exposes final s1/s2.    Rev 1.0
// ============================================================================
module goertzel_tone_detector #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int SW = 32,
    parameter int LW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LW-1:0]     blk_len,
    input  logic [CW-1:0]     coeff,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SW-1:0]   out_power,
`ifdef GOERTZEL_RAW_STATE_EN
    output logic [SW-1:0]     out_s1,
    output logic [SW-1:0]     out_s2,
`endif
    output logic              busy
);

    localparam int c_PW = 2 * SW + 1;
    localparam int c_MW = CW + SW;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCUM   = 3'd1,
        S_FIN_MUL = 3'd2,
        S_FIN_SUM = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [LW-1:0]           r_n;
    logic [LW-1:0]           r_cnt;
    logic signed [CW-1:0]    r_coeff;
    logic signed [SW-1:0]    r_s1;
    logic signed [SW-1:0]    r_s2;
    logic signed [c_PW-1:0]  r_p11;
    logic signed [c_PW-1:0]  r_p22;
    logic signed [c_PW-1:0]  r_pc;
    logic [2*SW-1:0]         r_power;
    logic                    r_out_valid;

    logic signed [c_MW-1:0]  w_prod;
    logic signed [SW-1:0]    w_cs1;
    logic signed [SW-1:0]    w_x;
    logic signed [SW-1:0]    w_s0;
    logic signed [c_PW-1:0]  w_s1x;
    logic signed [c_PW-1:0]  w_s2x;
    logic signed [c_PW-1:0]  w_csx;
    logic signed [c_PW-1:0]  w_sum;
    logic [2*SW-1:0]         w_pow;
    logic                    w_accept;
    logic                    w_last;

    // Q2 coefficient times s1, floor-shifted back to integer scale, wrapped to SW.
    assign w_prod   = r_coeff * r_s1;
    assign w_cs1    = SW'(w_prod >>> (CW - 2));
    assign w_x      = {{(SW - DW){in_data[DW-1]}}, in_data};
    assign w_s0     = w_x + w_cs1 - r_s2;

    assign w_s1x    = {{(c_PW - SW){r_s1[SW-1]}}, r_s1};
    assign w_s2x    = {{(c_PW - SW){r_s2[SW-1]}}, r_s2};
    assign w_csx    = {{(c_PW - SW){w_cs1[SW-1]}}, w_cs1};
    assign w_sum    = r_p11 + r_p22 - r_pc;
    assign w_pow    = w_sum[c_PW-1] ? '0 : w_sum[2*SW-1:0];

    assign w_accept = in_valid && (r_state == S_ACCUM);
    assign w_last   = (r_cnt == (r_n - LW'(1)));

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_ACCUM;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && w_last) w_next = S_FIN_MUL;
            end
            S_FIN_MUL: w_next = S_FIN_SUM;
            S_FIN_SUM: w_next = S_HOLD;
            S_HOLD: begin
                if (r_out_valid && out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_cnt       <= '0;
            r_coeff     <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_p11       <= '0;
            r_p22       <= '0;
            r_pc        <= '0;
            r_power     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n     <= (blk_len == '0) ? LW'(1) : blk_len;
                        r_coeff <= coeff;
                        r_s1    <= '0;
                        r_s2    <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_s2  <= r_s1;
                        r_s1  <= w_s0;
                        r_cnt <= r_cnt + LW'(1);
                    end
                end
                S_FIN_MUL: begin
                    r_p11 <= w_s1x * w_s1x;
                    r_p22 <= w_s2x * w_s2x;
                    r_pc  <= w_csx * w_s2x;
                end
                S_FIN_SUM: r_power <= w_pow;
                // Valid asserts one cycle into HOLD and drops on the consuming edge.
                S_HOLD: r_out_valid <= !(r_out_valid && out_ready);
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_power = r_power;

`ifdef GOERTZEL_RAW_STATE_EN
    assign out_s1 = r_s1;
    assign out_s2 = r_s2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_goertzel_tone_detector.sv
`default_nettype none
// ============================================================================
// tb_goertzel_tone_detector : directed bench with an arithmetic Goertzel model
// Rev 1.0
// ============================================================================
module tb_goertzel_tone_detector;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int SW = 32;
    localparam int LW = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LW-1:0]     blk_len;
    logic [CW-1:0]     coeff;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [2*SW-1:0]   out_power;
    logic              busy;
`ifdef GOERTZEL_RAW_STATE_EN
    logic [SW-1:0]     out_s1;
    logic [SW-1:0]     out_s2;
`endif

    always #5 clk = ~clk;

    goertzel_tone_detector #(.DW(DW), .CW(CW), .SW(SW), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .blk_len   (blk_len),
        .coeff     (coeff),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_power (out_power),
`ifdef GOERTZEL_RAW_STATE_EN
        .out_s1    (out_s1),
        .out_s2    (out_s2),
`endif
        .busy      (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    int          xs[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Straight Goertzel recursion in wide integers, then |X|^2 from the final pair.
    function automatic logic [63:0] model_power(input int c, input int n);
        longint s1 = 0;
        longint s2 = 0;
        longint s0;
        longint cs;
        int     nn = (n == 0) ? 1 : n;
        logic signed [64:0] a, b, d, p;
        for (int i = 0; i < nn; i++) begin
            cs = longint'(int'((longint'(c) * s1) >>> 14));
            s0 = longint'(int'(longint'(xs[i]) + cs - s2));
            s2 = s1;
            s1 = s0;
        end
        cs = longint'(int'((longint'(c) * s1) >>> 14));
        a = 65'(s1);
        b = 65'(s2);
        d = 65'(cs);
        p = a * a + b * b - d * b;
        return (p < 0) ? 64'd0 : p[63:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid actual=1 required=0");
            end else begin
                chk("out_power_vs_model", out_power, sb[0]);
                chk("in_ready_while_valid", {63'd0, in_ready}, 64'd0);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic do_start(input int c, input int n);
        start   = 1'b1;
        coeff   = CW'(c);
        blk_len = LW'(n);
        @(posedge clk); #1;
        start   = 1'b0;
        coeff   = CW'($urandom);
        blk_len = LW'($urandom);
    endtask

    task automatic send(input int d, input int gap);
        int k = 0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = DW'(d);
        while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic wait_result(input string name);
        int k = 0;
        while (!out_valid && k < 10) begin @(posedge clk); #1; k++; end
        chk({name, "_latency"}, 64'(k), 64'd3);
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
        chk({name, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic run_block(input string name, input int c, input int n, input int gap);
        int nn = (n == 0) ? 1 : n;
        sb.push_back(model_power(c, n));
        do_start(c, n);
        for (int i = 0; i < nn; i++) send(xs[i], gap);
        wait_result(name);
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        xs[0] = a; xs[1] = b; xs[2] = c; xs[3] = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int sine8[8];
        logic [63:0] pw;
        sine8 = '{0, 707, 1000, 707, 0, -707, -1000, -707};
        rst_n = 1'b0; start = 1'b0; blk_len = '0; coeff = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_power", out_power, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        load4(1000, 0, 0, 0);
        chk("model_impulse", model_power(0, 4), 64'd1000000);
        run_block("impulse", 0, 4, 0);
        chk("impulse_power", out_power, 64'd1000000);
`ifdef GOERTZEL_RAW_STATE_EN
        chk("impulse_s1", 64'(signed'(out_s1)), 64'd0);
        chk("impulse_s2", 64'(signed'(out_s2)), 64'(-1000));
`endif
        consume("impulse");

        load4(100, 0, -100, 0);
        chk("model_fs4", model_power(0, 4), 64'd40000);
        run_block("fs4", 0, 4, 0);
        chk("fs4_power", out_power, 64'd40000);
        consume("fs4");

        load4(100, 100, 100, 100);
        chk("model_dc", model_power(0, 4), 64'd0);
        run_block("dc", 0, 4, 0);
        chk("dc_power", out_power, 64'd0);
        consume("dc");

        load4(1000, 0, 0, 0);
        run_block("backpressure", 0, 4, 0);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            @(posedge clk); #1;
            chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
            chk("bp_busy", {63'd0, busy}, 64'd1);
            chk("bp_power_held", out_power, 64'd1000000);
        end
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        chk("bp_to_idle", {63'd0, busy}, 64'd0);
        chk("bp_valid_drop", {63'd0, out_valid}, 64'd0);
        repeat (3) @(posedge clk); #1;
        chk("bp_start_ignored", {63'd0, busy}, 64'd0);

        xs[0] = 500;
        chk("model_n1", model_power(0, 0), 64'd250000);
        run_block("n1", 0, 0, 0);
        chk("n1_power", out_power, 64'd250000);
        consume("n1");

        load4(100, 0, -100, 0);
        run_block("gaps", 0, 4, 2);
        chk("gaps_power", out_power, 64'd40000);
        consume("gaps");

        do_start(0, 4);
        send(1000, 0);
        send(0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_power", out_power, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", {63'd0, out_valid}, 64'd0);
        end
        load4(1000, 0, 0, 0);
        run_block("post_rst", 0, 4, 0);
        chk("post_rst_power", out_power, 64'd1000000);
        consume("post_rst");

        for (int i = 0; i < 64; i++) xs[i] = sine8[i % 8];
        run_block("inband", 23170, 64, 0);
        pw = out_power;
        checks++;
        if (pw < 64'd1013760000 || pw > 64'd1034240000) begin
            errors++;
            $display("FAIL inband_power actual=%0d required=1024000000+-1%%", pw);
        end
        consume("inband");

        for (int i = 0; i < 64; i++) xs[i] = (i % 4 == 1) ? 1000 : ((i % 4 == 3) ? -1000 : 0);
        run_block("stopband", 23170, 64, 0);
        pw = out_power;
        checks++;
        if (pw >= 64'd1024000) begin
            errors++;
            $display("FAIL stopband_power actual=%0d required=<1024000", pw);
        end
        consume("stopband");

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
